// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS-32 fetch stage that owns the PC and holds one instruction per execute window.
// Latency: 2 cycles per instruction at zero-wait memory; each memory wait or stall cycle adds one.
// Backpressure: imem_ready low holds FETCH with imem_addr stable; stall high holds EXEC with pc/instr frozen.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and word-aligned byte address (always equals pc)
//   imem_ready/imem_rdata memory response; rdata is captured when ready is seen in FETCH
//   stall                 extends the execute window
//   jump/branch/alu_zero  next-PC controls, sampled only on the EXEC cycle that retires
//   pc/instr/opcode       current instruction address, word and instr[31:26]
//   instr_valid           high during the execute window
//   retired_count         completed instructions, wraps at 2^32
//
// Build option: IMEM_WAIT_EN defined honours the imem_ready handshake. When undefined,
// FETCH always lasts one cycle, capturing imem_rdata then, and imem_ready is unused.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Low two bits of the reset vector are dropped so the PC is always word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] ret_q;
  logic [31:0] pc_plus4;
  logic [31:0] jmp_target;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        fetch_done;

`ifdef IMEM_WAIT_EN
  assign fetch_done = imem_ready;
`else
  // Port kept for a uniform interface; memory is assumed to answer in the fetch cycle.
  logic imem_ready_unused;
  assign imem_ready_unused = imem_ready;
  assign fetch_done        = 1'b1;
`endif

  assign pc_plus4   = pc_q + 32'd4;
  assign jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign br_target  = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump outranks a taken branch; all adds wrap modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jmp_target;
    end else if (branch && alu_zero) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      ret_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && fetch_done) begin
        instr_q <= imem_rdata;
      end
      if (state == EXEC && !stall) begin
        pc_q  <= next_pc;
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  // Next state plus state-decoded outputs; nothing here depends on the
  // handshake or control inputs except the next-state choice.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (fetch_done) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:26];
  assign retired_count = ret_q;

endmodule
